// File: rtl/mod3_pkg.sv
// Shared encodings for the word scheduler and its serial mod-3 core.
package mod3_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SHIFT,
    CAPTURE,
    RESP
  } state_t;

  typedef enum logic [1:0] {
    R0 = 2'd0,
    R1 = 2'd1,
    R2 = 2'd2
  } residue_t;

  // Next residue after appending one bit: (2r + b) mod 3.
  function automatic residue_t mod3_step(input residue_t r, input logic b);
    residue_t nxt;
    nxt = R0;
    case (r)
      R0:      nxt = b ? R1 : R0;
      R1:      nxt = b ? R0 : R2;
      R2:      nxt = b ? R2 : R1;
      default: nxt = R0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mod3_serial_core.sv
// Bit-serial multiple-of-three detector: tracks the residue of the MSB-first bit stream.
module mod3_serial_core
  import mod3_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic bit_en,
  input  logic bit_in,
  output logic div3
);

  residue_t residue;

  // Residue register; clear wins over a simultaneous bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      residue <= R0;
    end else if (clr) begin
      residue <= R0;
    end else if (bit_en) begin
      residue <= mod3_step(residue, bit_in);
    end
  end

  assign div3 = (residue == R0);

endmodule

// File: rtl/mod3_word_scheduler.sv
// Arbitrates two word requesters onto one serial mod-3 core and returns the verdict.
module mod3_word_scheduler
  import mod3_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_div3,
  output logic             busy
);

  state_t           state;
  logic             last_grant;
  logic             grant;
  logic             accept;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] shift_q;
  logic             id_q;
  logic             shift_done;
  logic             core_clr;
  logic             core_bit_en;
  logic             core_div3;

  // Round-robin choice: a lone requester wins; on contention the one not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else begin
      grant = req1_valid;
    end
  end

  assign req0_ready  = (state == IDLE) && !grant;
  assign req1_ready  = (state == IDLE) && grant;
  assign accept      = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // SHIFT lasts WIDTH+1 cycles: WIDTH bit cycles plus the cycle that sees the full count.
  assign shift_done  = (bit_cnt == CNT_W'(WIDTH));
  assign core_clr    = (state == CLEAR);
  assign core_bit_en = (state == SHIFT) && !shift_done;

  mod3_serial_core u_core (
    .clk    (clk),
    .reset  (reset),
    .clr    (core_clr),
    .bit_en (core_bit_en),
    .bit_in (shift_q[WIDTH-1]),
    .div3   (core_div3)
  );

  // Transaction sequencer with registered response and busy outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      bit_cnt    <= '0;
      word_q     <= '0;
      shift_q    <= '0;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_data   <= '0;
      rsp_div3   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            word_q     <= grant ? req1_data : req0_data;
            shift_q    <= grant ? req1_data : req0_data;
            id_q       <= grant;
            last_grant <= grant;
            busy       <= 1'b1;
            state      <= CLEAR;
          end
        end
        CLEAR: begin
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (shift_done) begin
            state <= CAPTURE;
          end else begin
            shift_q <= shift_q << 1;
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        CAPTURE: begin
          rsp_div3  <= core_div3;
          rsp_id    <= id_q;
          rsp_data  <= word_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
